// File: rtl/rib_timer_slave_pkg.sv
// Shared definitions for the RIB timer slave: widths, register offsets and CTRL layout.
package rib_timer_slave_pkg;

   localparam int unsigned TIMER_DW      = 32;
   localparam int unsigned TIMER_AW      = 32;
   localparam int unsigned TIMER_PRESC_W = 16;

   // Word offsets, decoded from addr_i[3:2]
   typedef enum logic [1:0] {
      TIMER_CTRL  = 2'd0,
      TIMER_VALUE = 2'd1,
      TIMER_CMP   = 2'd2,
      TIMER_PRESC = 2'd3
   } timer_reg_e;

   localparam int unsigned CTRL_EN       = 0;
   localparam int unsigned CTRL_INT_EN   = 1;
   localparam int unsigned CTRL_PERIODIC = 2;
   localparam int unsigned CTRL_PEND     = 3;
   localparam int unsigned CTRL_W        = 4;

   // Field order matches the CTRL bit indices above (en is bit 0)
   typedef struct packed {
      logic pend;
      logic periodic;
      logic int_en;
      logic en;
   } timer_ctrl_t;

endpackage

// File: rtl/rib_timer_slave_prescaler.sv
// Prescaler for the RIB timer: counts 0..presc while enabled, ticks on the terminal count.
module rib_timer_slave_prescaler #(
   parameter int unsigned PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick_c
);

   logic [PRESC_W-1:0] pcnt_q;

   // >= so a shrinking divisor below the current count wraps immediately
   assign tick_c = en && (pcnt_q >= presc);

   // Held at zero while disabled, so an enable edge always restarts from 0
   always_ff @(posedge clk) begin
      if (rst || !en || tick_c) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_q + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/rib_timer_slave.sv
// Memory-mapped prescaled timer on a RIB slave port: compare match, one-shot/periodic,
// sticky pending flag and a level interrupt.
module rib_timer_slave
   import rib_timer_slave_pkg::*;
#(
   parameter int unsigned DW      = TIMER_DW,
   parameter int unsigned AW      = TIMER_AW,
   parameter int unsigned PRESC_W = TIMER_PRESC_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   input  logic          we_i,
   output logic [DW-1:0] data_o,
   output logic          int_sig_o
);

   timer_ctrl_t        ctrl_q, ctrl_d;
   logic [DW-1:0]      value_q, value_d;
   logic [DW-1:0]      cmp_q, cmp_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               int_q;
   logic               tick;
   logic               count;
   logic               match;
   logic               wr_ctrl, wr_value, wr_cmp, wr_presc;
   timer_reg_e         sel;
   logic               addr_unused;

   assign sel         = timer_reg_e'(addr_i[3:2]);
   assign addr_unused = ^{addr_i[AW-1:4], addr_i[1:0]};

   rib_timer_slave_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .en     (ctrl_q.en),
      .presc  (presc_q),
      .tick_c (tick)
   );

   // Next-state: hardware counter first, then bus writes override, then pend set wins
   always_comb begin
      ctrl_d   = ctrl_q;
      value_d  = value_q;
      cmp_d    = cmp_q;
      presc_d  = presc_q;
      wr_ctrl  = we_i && (sel == TIMER_CTRL);
      wr_value = we_i && (sel == TIMER_VALUE);
      wr_cmp   = we_i && (sel == TIMER_CMP);
      wr_presc = we_i && (sel == TIMER_PRESC);
      count    = tick && !wr_value;
      match    = count && (value_q == cmp_q);

      if (count) begin
         if (match) begin
            if (ctrl_q.periodic) begin
               value_d = '0;
            end else begin
               ctrl_d.en = 1'b0;
            end
         end else begin
            value_d = value_q + DW'(1);
         end
      end

      if (wr_value) value_d = data_i;
      if (wr_cmp)   cmp_d   = data_i;
      if (wr_presc) presc_d = data_i[PRESC_W-1:0];

      if (wr_ctrl) begin
         ctrl_d.en       = data_i[CTRL_EN];
         ctrl_d.int_en   = data_i[CTRL_INT_EN];
         ctrl_d.periodic = data_i[CTRL_PERIODIC];
         if (data_i[CTRL_PEND]) ctrl_d.pend = 1'b0;
      end

      if (match) ctrl_d.pend = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q  <= '0;
         value_q <= '0;
         cmp_q   <= '1;
         presc_q <= '0;
         int_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         value_q <= value_d;
         cmp_q   <= cmp_d;
         presc_q <= presc_d;
         int_q   <= ctrl_q.pend & ctrl_q.int_en;
      end
   end

   assign int_sig_o = int_q;

   // Zero-wait-state read mux; forced to zero while in reset
   always_comb begin
      data_o = '0;
      if (!rst) begin
         case (sel)
            TIMER_CTRL:  data_o = {{(DW-CTRL_W){1'b0}}, ctrl_q};
            TIMER_VALUE: data_o = value_q;
            TIMER_CMP:   data_o = cmp_q;
            TIMER_PRESC: data_o = {{(DW-PRESC_W){1'b0}}, presc_q};
            default:     data_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_rib_timer_slave.sv
// Directed self-checking bench for rib_timer_slave.
module tb_rib_timer_slave;

   localparam logic [31:0] A_CTRL  = 32'h0;
   localparam logic [31:0] A_VALUE = 32'h4;
   localparam logic [31:0] A_CMP   = 32'h8;
   localparam logic [31:0] A_PRESC = 32'hC;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic        irq;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   rib_timer_slave dut (
      .clk       (clk),
      .rst       (rst),
      .addr_i    (addr),
      .data_i    (wdata),
      .we_i      (we),
      .data_o    (rdata),
      .int_sig_o (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      step();
      we    = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] wrap_seq [4];
      wrap_seq[0] = 32'hFFFF_FFFE;
      wrap_seq[1] = 32'hFFFF_FFFF;
      wrap_seq[2] = 32'h0;
      wrap_seq[3] = 32'h1;

      // 1: reset
      rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
      step(); step();
      rd_chk("rst_hold_rdata", A_CMP, 32'h0);
      rst = 1'b0;
      rd_chk("rst_ctrl",  A_CTRL,  32'h0);
      rd_chk("rst_value", A_VALUE, 32'h0);
      rd_chk("rst_cmp",   A_CMP,   32'hFFFF_FFFF);
      rd_chk("rst_presc", A_PRESC, 32'h0);
      check("rst_irq", irq, 32'h0);

      // 2: one-shot
      wr(A_PRESC, 32'h0);
      wr(A_CMP, 32'h5);
      wr(A_CTRL, 32'h3);
      rd_chk("os_value_0", A_VALUE, 32'h0);
      for (int i = 1; i <= 5; i++) begin
         step();
         rd_chk($sformatf("os_value_%0d", i), A_VALUE, 32'(i));
      end
      step();
      rd_chk("os_ctrl_match", A_CTRL, 32'hA);
      check("os_irq_lag", irq, 32'h0);
      step();
      check("os_irq_set", irq, 32'h1);
      rd_chk("os_value_held", A_VALUE, 32'h5);
      wr(A_CTRL, 32'h8);
      rd_chk("os_ctrl_clr", A_CTRL, 32'h0);
      check("os_irq_clr_lag", irq, 32'h1);
      step();
      check("os_irq_clr", irq, 32'h0);

      // 3: periodic with prescaler
      wr(A_VALUE, 32'h0);
      wr(A_PRESC, 32'h3);
      wr(A_CMP, 32'h2);
      wr(A_CTRL, 32'h7);
      rd_chk("per_value_0", A_VALUE, 32'h0);
      for (int k = 1; k <= 12; k++) begin
         step();
         rd_chk($sformatf("per_ctrl_%0d", k), A_CTRL, (k == 12) ? 32'hF : 32'h7);
         if (k % 4 == 0)
            rd_chk($sformatf("per_value_%0d", k), A_VALUE, (k == 12) ? 32'h0 : 32'(k / 4));
      end
      wr(A_CTRL, 32'hF);
      rd_chk("per_pend_clr", A_CTRL, 32'h7);
      for (int k = 14; k <= 24; k++) begin
         step();
         if (k == 23) rd_chk("per_pend_pre", A_CTRL, 32'h7);
         if (k == 24) rd_chk("per_pend_again", A_CTRL, 32'hF);
      end
      wr(A_CTRL, 32'h8);
      rd_chk("per_stop", A_CTRL, 32'h0);

      // 4: collisions
      wr(A_VALUE, 32'h0);
      wr(A_CMP, 32'h3);
      wr(A_PRESC, 32'h0);
      wr(A_CTRL, 32'h1);
      step(); step(); step();
      rd_chk("col_value_pre", A_VALUE, 32'h3);
      wr(A_CTRL, 32'h9);
      rd_chk("col_set_wins", A_CTRL, 32'h9);
      rd_chk("col_value_held", A_VALUE, 32'h3);
      wr(A_CTRL, 32'h8);
      wr(A_CTRL, 32'h8);
      rd_chk("col_w1c", A_CTRL, 32'h0);
      wr(A_VALUE, 32'h0);
      wr(A_CMP, 32'hFFFF_FFFF);
      wr(A_CTRL, 32'h1);
      step(); step();
      rd_chk("col_run", A_VALUE, 32'h2);
      wr(A_VALUE, 32'h10);
      rd_chk("col_bus_wins", A_VALUE, 32'h10);
      step();
      rd_chk("col_after", A_VALUE, 32'h11);
      wr(A_CTRL, 32'h0);

      // 5: wrap
      wr(A_VALUE, 32'hFFFF_FFFE);
      wr(A_CMP, 32'h1);
      wr(A_CTRL, 32'h3);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) step();
         rd_chk($sformatf("wrap_value_%0d", i), A_VALUE, wrap_seq[i]);
         rd_chk($sformatf("wrap_ctrl_%0d", i), A_CTRL, 32'h3);
      end
      step();
      rd_chk("wrap_match", A_CTRL, 32'hA);
      rd_chk("wrap_value_held", A_VALUE, 32'h1);

      // 6: reset mid-run
      wr(A_CTRL, 32'h8);
      wr(A_VALUE, 32'h0);
      wr(A_CMP, 32'h2);
      wr(A_CTRL, 32'h7);
      step(); step(); step(); step();
      rd_chk("mid_pend", A_CTRL, 32'hF);
      check("mid_irq", irq, 32'h1);
      rst = 1'b1;
      step();
      rd_chk("mid_rst_rdata", A_CMP, 32'h0);
      check("mid_rst_irq", irq, 32'h0);
      rst = 1'b0;
      rd_chk("mid_ctrl",  A_CTRL,  32'h0);
      rd_chk("mid_value", A_VALUE, 32'h0);
      rd_chk("mid_cmp",   A_CMP,   32'hFFFF_FFFF);
      rd_chk("mid_presc", A_PRESC, 32'h0);
      step(); step();
      rd_chk("mid_idle_value", A_VALUE, 32'h0);
      check("mid_idle_irq", irq, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
